alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Front-panel controller that sequences one ALU operation from switches and push-buttons. It debounces and edge-detects the buttons, then loads operand A, operand B and the opcode from sw[7:0] in order. It launches the ALU with a start/done handshake and holds the result (or flags) on the display outputs. It sits between the top-level pin mapping and the ALU datapath (Procesamiento), replacing direct button-to-datapath wiring.

Parameters:
DEB_CYCLES, 16, cycles a synchronized button level must stay stable before it is accepted (min 2).
TIMEOUT_CYCLES, 64, max cycles to wait for alu_done after alu_start before entering ERR.
OP_W, 4, opcode width taken from sw[OP_W-1:0].

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  reset, synchronous, active-high.
sw  in  8  operand/opcode switches.
btn_next  in  1  advance / confirm (async raw).
btn_back  in  1  step back one load stage; toggles result/flags view in SHOW (async raw).
btn_clr  in  1  abort to LOAD_A (async raw).
alu_a  out  8  registered operand A to ALU.
alu_b  out  8  registered operand B to ALU.
alu_op  out  OP_W  registered opcode to ALU.
alu_start  out  1  single-cycle launch pulse.
alu_done  in  1  ALU completion, sampled when in EXEC.
alu_result  in  8  ALU result, captured on alu_done.
alu_flags  in  4  ALU flags {C,Z,N,V}, captured on alu_done.
disp  out  8  value for LEDs/uo.
state_o  out  3  current state encoding.
err  out  1  sticky timeout indicator.

Behaviour:
- Reset: state = LOAD_A (001); alu_a, alu_b, alu_op, result_reg and flags_reg = 0; alu_start = 0; err = 0; disp = 0; debouncers cleared with accepted level = 0. rst overrides everything, including mid-EXEC.
- Button path, per button: 2-FF synchronizer, then a counter that resets on any level change. The level is accepted after DEB_CYCLES stable cycles. A rising edge of the accepted level gives a 1-cycle pulse. Press-to-pulse latency = 2 + DEB_CYCLES + 1 cycles. Holding a button produces exactly one pulse.
- Simultaneous pulses: priority is clr > back > next.
- States (state_o encoding): LOAD_A=1, LOAD_B=2, LOAD_OP=3, EXEC=4, SHOW=5, ERR=6.
- LOAD_A: disp = sw (live).
  - next: alu_a <= sw, go to LOAD_B.
  - back: ignored.
- LOAD_B: disp = sw.
  - next: alu_b <= sw, go to LOAD_OP.
  - back: go to LOAD_A; alu_a is retained.
- LOAD_OP: disp = {0, sw[OP_W-1:0]}.
  - next: alu_op <= sw[OP_W-1:0], alu_start = 1 in the following cycle, go to EXEC.
  - back: go to LOAD_B.
- EXEC:
  - alu_start is high only on the first EXEC cycle.
  - A timeout counter starts at 0 on entry.
  - alu_done = 1: capture result/flags, go to SHOW next cycle. This includes done in the same cycle as start (minimum latency).
  - Counter reaches TIMEOUT_CYCLES without done: go to ERR.
  - next/back are ignored; clr aborts to LOAD_A and alu_done is ignored that cycle.
  - disp holds its previous value.
- SHOW:
  - disp = result_reg, or {4'b0, flags_reg} when the view bit is set. back toggles the view bit; it is cleared on entry.
  - next: go to LOAD_A with operands kept, so A is pre-displayed as sw only.
- ERR: err = 1 (sticky until rst or clr); disp = 8'hEE; only clr exits, to LOAD_A.
- clr: from any state, go to LOAD_A; clears err and the view bit; operand registers unchanged.
- alu_done outside EXEC is ignored.
- alu_a/alu_b/alu_op change only on their load confirm, never during EXEC.

Test Plan (DEB_CYCLES=4, TIMEOUT_CYCLES=8):
1. rst high 2 cycles, then release -> state_o=1, disp=0, err=0, alu_start never asserted.
2. Full sequence with a model ALU adding and done 3 cycles after start:
   - sw=8'h25 + next -> alu_a=25h.
   - sw=8'h1A + next -> alu_b=1Ah.
   - sw=4'h0 + next -> exactly one alu_start pulse, then SHOW with disp=8'h3F.
   - back -> disp=flags.
3. Bounce glitches of 1–3 cycles on btn_next -> no pulse; 6-cycle stable press held for 50 cycles -> exactly one state advance.
4. In LOAD_OP press back, then change sw=8'h77 in LOAD_B and press next -> alu_b=77h, alu_a unchanged.
5. ALU never asserts done -> ERR after 8 EXEC cycles, disp=EEh, err=1; next ignored; clr -> LOAD_A, err=0.
6. Press clr and next together in LOAD_B -> LOAD_A. Assert rst during EXEC -> LOAD_A with all registers 0; a later alu_done pulse causes no change.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - front-panel sequencer: debounced buttons load A, B, opcode, then run one ALU op
// Button index map: 0 = next, 1 = back, 2 = clr.
module alu_op_sequencer #(
  parameter int DEB_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int OP_W           = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      sw,
  input  logic            btn_next,
  input  logic            btn_back,
  input  logic            btn_clr,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [OP_W-1:0] alu_op,
  output logic            alu_start,
  input  logic            alu_done,
  input  logic [7:0]      alu_result,
  input  logic [3:0]      alu_flags,
  output logic [7:0]      disp,
  output logic [2:0]      state_o,
  output logic            err
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    LOAD_OP = 3'd3,
    EXEC    = 3'd4,
    SHOW    = 3'd5,
    ERR     = 3'd6
  } state_t;

  state_t state, next_state;

  logic [2:0]    raw, sync1, sync2, lvl, acc, acc_d, pulse;
  logic [CW-1:0] deb_cnt [3];

  assign raw   = {btn_clr, btn_back, btn_next};
  assign pulse = acc & ~acc_d;

  // The accepted level only follows sync2 once it has held still long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      acc   <= '0;
      acc_d <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      acc_d <= acc;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != lvl[i]) begin
          lvl[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] != CW'(DEB_CYCLES - 1)) begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end else begin
          acc[i] <= lvl[i];
        end
      end
    end
  end

  logic          clr_p, back_p, next_p;
  logic          ld_a, ld_b, ld_op, capture, view_tgl;
  logic          view;
  logic [TW-1:0] tcnt;
  logic [7:0]    result_reg, disp_n;
  logic [3:0]    flags_reg;

  assign clr_p  = pulse[2];
  assign back_p = pulse[1];
  assign next_p = pulse[0];

  always_comb begin
    next_state = state;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_op      = 1'b0;
    capture    = 1'b0;
    view_tgl   = 1'b0;
    disp_n     = disp;
    if (clr_p) begin
      next_state = LOAD_A;
    end else begin
      case (state)
        LOAD_A: if (next_p) begin
          ld_a       = 1'b1;
          next_state = LOAD_B;
        end
        LOAD_B: begin
          if (back_p) next_state = LOAD_A;
          else if (next_p) begin
            ld_b       = 1'b1;
            next_state = LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (back_p) next_state = LOAD_B;
          else if (next_p) begin
            ld_op      = 1'b1;
            next_state = EXEC;
          end
        end
        EXEC: begin
          if (alu_done) begin
            capture    = 1'b1;
            next_state = SHOW;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            next_state = ERR;
          end
        end
        SHOW: begin
          if (back_p) view_tgl = 1'b1;
          else if (next_p) next_state = LOAD_A;
        end
        ERR: next_state = ERR;
        default: next_state = LOAD_A;
      endcase
    end
    case (state)
      LOAD_A, LOAD_B: disp_n = sw;
      LOAD_OP:        disp_n = 8'(sw[OP_W-1:0]);
      SHOW:           disp_n = view ? {4'b0, flags_reg} : result_reg;
      ERR:            disp_n = 8'hEE;
      default:        disp_n = disp;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD_A;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      result_reg <= '0;
      flags_reg  <= '0;
      tcnt       <= '0;
      view       <= 1'b0;
      err        <= 1'b0;
      disp       <= '0;
    end else begin
      state     <= next_state;
      alu_start <= ld_op;
      tcnt      <= (state == EXEC) ? tcnt + 1'b1 : '0;
      disp      <= disp_n;
      if (ld_a)  alu_a  <= sw;
      if (ld_b)  alu_b  <= sw;
      if (ld_op) alu_op <= sw[OP_W-1:0];
      if (capture) begin
        result_reg <= alu_result;
        flags_reg  <= alu_flags;
      end
      if (clr_p) err <= 1'b0;
      else if (next_state == ERR) err <= 1'b1;
      // View always opens on the result after each new operation.
      if (clr_p || (state != SHOW && next_state == SHOW)) view <= 1'b0;
      else if (view_tgl) view <= ~view;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized bench for alu_op_sequencer against a press-level reference model
module tb_alu_op_sequencer;

  localparam int DEB = 4;
  localparam int TO  = 8;
  localparam int NEVER = 99;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw = 8'h00;
  logic [2:0] btns = 3'b000;
  logic [7:0] alu_a, alu_b, disp;
  logic [3:0] alu_op;
  logic       alu_start, err;
  logic [2:0] state_o;
  logic       alu_done = 1'b0;
  logic [7:0] alu_result = 8'h00;
  logic [3:0] alu_flags = 4'h0;

  alu_op_sequencer #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TO), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .btn_next(btns[0]), .btn_back(btns[1]), .btn_clr(btns[2]),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
    .disp(disp), .state_o(state_o), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bench ALU: an arbitrary but fixed function; op 0 with these operands reduces to a + b.
  function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [7:0] r;
    r = (a ^ {4'b0, op}) + b;
    return {r[7], (r == 8'h00), op[0], r[0], r};
  endfunction

  int   alu_delay = 3;
  int   alu_cnt = 0;
  logic alu_busy = 1'b0;
  logic force_done = 1'b0;
  int   starts = 0;

  always @(negedge clk) begin
    alu_done = force_done;
    if (alu_start) begin
      starts++;
      alu_busy = 1'b1;
      alu_cnt = 0;
    end
    if (alu_busy) begin
      if (alu_cnt == alu_delay) begin
        alu_done = 1'b1;
        {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_op);
        alu_busy = 1'b0;
      end
      alu_cnt++;
    end
  end

  int         m_st = 1;
  logic [7:0] m_a = 0, m_b = 0, m_res = 0;
  logic [3:0] m_op = 0, m_flags = 0;
  logic       m_view = 0, m_err = 0;

  task automatic model_reset();
    m_st = 1; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0; m_view = 0; m_err = 0;
  endtask

  task automatic model_press(input logic [2:0] b, input int d);
    if (b[2]) begin
      m_st = 1; m_err = 0; m_view = 0;
    end else if (b[1]) begin
      case (m_st)
        2: m_st = 1;
        3: m_st = 2;
        5: m_view = ~m_view;
        default: ;
      endcase
    end else if (b[0]) begin
      case (m_st)
        1: begin m_a = sw; m_st = 2; end
        2: begin m_b = sw; m_st = 3; end
        3: begin
          m_op = sw[3:0];
          if (d < TO) begin
            {m_flags, m_res} = alu_fn(m_a, m_b, m_op);
            m_st = 5; m_view = 0;
          end else begin
            m_st = 6; m_err = 1;
          end
        end
        5: m_st = 1;
        default: ;
      endcase
    end
  endtask

  function automatic logic [7:0] exp_disp();
    case (m_st)
      1, 2:    return sw;
      3:       return {4'b0, sw[3:0]};
      5:       return m_view ? {4'b0, m_flags} : m_res;
      default: return 8'hEE;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(state_o), 32'(m_st));
    check({tag, ".a"},     32'(alu_a),   32'(m_a));
    check({tag, ".b"},     32'(alu_b),   32'(m_b));
    check({tag, ".op"},    32'(alu_op),  32'(m_op));
    check({tag, ".err"},   32'(err),     32'(m_err));
    check({tag, ".disp"},  32'(disp),    32'(exp_disp()));
  endtask

  task automatic press(input logic [2:0] b, input int hold);
    @(negedge clk);
    btns = b;
    repeat (hold) @(negedge clk);
    btns = 3'b000;
    repeat (24) @(negedge clk);
    model_press(b, alu_delay);
  endtask

  initial begin
    int s0;
    logic [2:0] b;
    bit reached;

    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst.state", 32'(state_o), 32'd1);
    check("rst.disp", 32'(disp), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    repeat (10) @(negedge clk);
    check("rst.nostart", 32'(starts), 32'd0);
    check_all("rst");

    // Full add sequence
    sw = 8'h25; press(3'b001, 12); check_all("seq.a");
    sw = 8'h1A; press(3'b001, 12); check_all("seq.b");
    s0 = starts;
    sw = 8'h00; press(3'b001, 12); check_all("seq.exec");
    check("seq.disp3f", 32'(disp), 32'h3F);
    check("seq.onestart", 32'(starts - s0), 32'd1);
    press(3'b010, 12); check_all("seq.flags");
    press(3'b010, 12); check_all("seq.result");
    press(3'b001, 12); check_all("seq.back_to_a");

    // Bounce glitches then one long press
    for (int g = 1; g <= 3; g++) begin
      @(negedge clk); btns = 3'b001;
      repeat (g) @(negedge clk);
      btns = 3'b000;
      repeat (12) @(negedge clk);
    end
    check("bounce.nomove", 32'(state_o), 32'd1);
    sw = 8'h5C; press(3'b001, 50); check_all("bounce.long");

    // Back from LOAD_OP, reload B
    sw = 8'h11; press(3'b001, 12); check_all("back.op");
    press(3'b010, 12); check_all("back.to_b");
    sw = 8'h77; press(3'b001, 12); check_all("back.b77");
    check("back.b77v", 32'(alu_b), 32'h77);

    // Timeout
    alu_delay = NEVER;
    sw = 8'h03; press(3'b001, 12); check_all("to.err");
    check("to.ee", 32'(disp), 32'hEE);
    press(3'b001, 12); check_all("to.next_ignored");
    press(3'b100, 12); check_all("to.clr");

    // clr and next together in LOAD_B
    alu_delay = 3;
    sw = 8'h40; press(3'b001, 12); check_all("sim.b");
    press(3'b101, 12); check_all("sim.clr_wins");

    // Reset during EXEC, then a stray done
    alu_delay = NEVER;
    sw = 8'h09; press(3'b001, 12);
    press(3'b001, 12); check_all("rx.op");
    @(negedge clk); btns = 3'b001;
    reached = 1'b0;
    for (int c = 0; c < 40 && !reached; c++) begin
      @(negedge clk);
      if (state_o == 3'd4) reached = 1'b1;
    end
    check("rx.exec_reached", 32'(reached), 32'd1);
    btns = 3'b000; rst = 1'b1; sw = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all("rx.reset");
    repeat (3) @(negedge clk);
    force_done = 1'b1; @(negedge clk); force_done = 1'b0;
    repeat (5) @(negedge clk);
    check_all("rx.stray_done");

    // Randomized press sequences
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      b = (r == 0) ? 3'b100 : (r < 3) ? 3'b010 : 3'b001;
      if (m_st == 6 && $urandom_range(0, 1) == 1) b = 3'b100;
      sw = 8'($urandom);
      alu_delay = $urandom_range(0, 8);
      if (alu_delay == 8) alu_delay = NEVER;
      press(b, 12);
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
